// File: rtl/pixel_readback_pkg.sv
// Shared types and helpers for the pixel_readback shadow framebuffer.
// Screen geometry, FSM state encoding and the shift-add address map live here.
package pixel_readback_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int COLOR_BITS = 3;
    localparam int ADDR_BITS  = 15;
    localparam int NUM_PIXELS = SCREEN_W * SCREEN_H;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // y*160 + x as (y<<7) + (y<<5) + x so no multiplier is inferred.
    function automatic logic [ADDR_BITS-1:0] xy_to_addr(input logic [7:0] x,
                                                        input logic [6:0] y);
        logic [ADDR_BITS-1:0] yw;
        logic [ADDR_BITS-1:0] xw;
        yw = {8'd0, y};
        xw = {7'd0, x};
        return (yw << 7) + (yw << 5) + xw;
    endfunction

endpackage

// File: rtl/pixel_readback_shadow_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port, old data on collision.
// Without PIXEL_READBACK_CLEAR_EN the array is preloaded from obstacle_course.mif.
module shadow_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

`ifdef PIXEL_READBACK_CLEAR_EN
    logic [DW-1:0] mem_q [DEPTH];
`else
    (* ram_init_file = "obstacle_course.mif" *) logic [DW-1:0] mem_q [DEPTH];
`endif

    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_readback.sv
// Shadow copy of the 160x120 display written by snooping plot strobes, with a pixel read port.
// PIXEL_READBACK_CLEAR_EN adds a post-reset clear pass; otherwise RAM keeps its preloaded image.
module pixel_readback
    import pixel_readback_pkg::*;
#(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int COLOR_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            wr_x,
    input  logic [6:0]            wr_y,
    input  logic [COLOR_BITS-1:0] wr_color,
    input  logic                  wr_plot,
    input  logic                  rd_req,
    input  logic [7:0]            rd_x,
    input  logic [6:0]            rd_y,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [COLOR_BITS-1:0] rd_color,
    output logic                  rd_oob
);

`ifdef PIXEL_READBACK_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic                    oob_q, oob_d;
    logic                    rd_ready_q, rd_ready_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [COLOR_BITS-1:0]   rd_color_q, rd_color_d;
    logic                    rd_oob_q, rd_oob_d;

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_commit;
    logic                    rd_accept;
    logic [ADDR_BITS-1:0]    wr_addr;
    logic [ADDR_BITS-1:0]    rd_addr;

    logic                    ram_we;
    logic                    ram_re;
    logic [ADDR_BITS-1:0]    ram_waddr;
    logic [COLOR_BITS-1:0]   ram_wdata;
    logic [COLOR_BITS-1:0]   ram_rdata;

    assign wr_in_range = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    assign rd_in_range = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
    assign wr_commit   = wr_plot && wr_in_range;
    assign rd_accept   = rd_req && rd_ready_q;
    assign wr_addr     = xy_to_addr(wr_x, wr_y);
    assign rd_addr     = xy_to_addr(rd_x, rd_y);

`ifdef PIXEL_READBACK_CLEAR_EN
    logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic                 clr_done;

    // A snooped write takes the RAM port; the clear counter simply waits a cycle.
    always_comb begin
        clr_cnt_d = clr_cnt_q;
        clr_done  = 1'b0;
        if (state_q == ST_CLEAR && !wr_commit) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            clr_done  = (clr_cnt_q == ADDR_BITS'(NUM_PIXELS - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    always_comb begin
        ram_we    = wr_commit;
        ram_waddr = wr_addr;
        ram_wdata = wr_color;
`ifdef PIXEL_READBACK_CLEAR_EN
        if (state_q == ST_CLEAR && !wr_commit) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = '0;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        oob_d      = oob_q;
        rd_valid_d = 1'b0;
        rd_color_d = rd_color_q;
        rd_oob_d   = rd_oob_q;
        ram_re     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
`ifdef PIXEL_READBACK_CLEAR_EN
                if (clr_done) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (rd_accept) begin
                    // Out-of-range reads park on address 0; the flag masks the data later.
                    addr_d  = rd_in_range ? rd_addr : '0;
                    oob_d   = !rd_in_range;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                ram_re  = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rd_valid_d = 1'b1;
                rd_color_d = oob_q ? '0 : ram_rdata;
                rd_oob_d   = oob_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        rd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            rd_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_color_q <= '0;
            rd_oob_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ready_q <= rd_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_color_q <= rd_color_d;
            rd_oob_q   <= rd_oob_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        oob_q  <= oob_d;
    end

    shadow_ram #(
        .DEPTH (NUM_PIXELS),
        .AW    (ADDR_BITS),
        .DW    (COLOR_BITS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (addr_q),
        .rdata_o (ram_rdata)
    );

    assign rd_ready = rd_ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_color = rd_color_q;
    assign rd_oob   = rd_oob_q;

endmodule

// File: tb/tb_pixel_readback.sv
// Randomised bench for pixel_readback against a framebuffer-array reference model.
// Covers both builds; clear-specific checks are compiled in with PIXEL_READBACK_CLEAR_EN.
module tb_pixel_readback;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_x, rd_x;
    logic [6:0] wr_y, rd_y;
    logic [2:0] wr_color, rd_color;
    logic       wr_plot, rd_req;
    logic       rd_ready, rd_valid, rd_oob;

    int checks = 0;
    int errors = 0;

    // Reference state: pixel array plus the read handshake seen as simple counters.
    logic [2:0] fb [160*120];
    int         vcnt;
    bit         ready_m, valid_m, startup, oob_m, pend_oob;
    logic [2:0] color_m, pend_color;

    pixel_readback #(.WIDTH(160), .HEIGHT(120), .COLOR_BITS(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_color (wr_color),
        .wr_plot  (wr_plot),
        .rd_req   (rd_req),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_color (rd_color),
        .rd_oob   (rd_oob)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit inr(input int x, input int y);
        return (x < 160) && (y < 120);
    endfunction

    function automatic int rnd_coord(input int lo_max, input int hi_min, input int hi_max);
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, lo_max));
        return int'($urandom_range(hi_min, hi_max));
    endfunction

    // One clock edge: update the model for this edge, then compare DUT outputs after it.
    task automatic tick();
        bit acc;
        int wx, wy, rx, ry;
        wx  = int'(wr_x); wy = int'(wr_y); rx = int'(rd_x); ry = int'(rd_y);
        acc = rd_req && ready_m;
        if (wr_plot && inr(wx, wy)) fb[wy*160 + wx] = wr_color;
        if (acc) begin
            pend_oob   = !inr(rx, ry);
            pend_color = pend_oob ? 3'd0 : fb[ry*160 + rx];
        end
        @(posedge clk); #1;
        valid_m = 1'b0;
        if (vcnt > 0) begin
            vcnt--;
            if (vcnt == 0) begin
                valid_m = 1'b1;
                color_m = pend_color;
                oob_m   = pend_oob;
            end
        end
        if (acc) begin
            vcnt    = 2;
            ready_m = 1'b0;
        end else if (valid_m || startup) begin
            ready_m = 1'b1;
        end
        startup = 1'b0;
        check_eq("rd_ready", int'(rd_ready), int'(ready_m));
        check_eq("rd_valid", int'(rd_valid), int'(valid_m));
        check_eq("rd_color", int'(rd_color), int'(color_m));
        check_eq("rd_oob",   int'(rd_oob),   int'(oob_m));
    endtask

    task automatic do_reset(input bit stall_write);
        int n;
        reset   = 1'b1;
        wr_plot = 1'b0;
        rd_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vcnt = 0; ready_m = 1'b0; valid_m = 1'b0; color_m = 3'd0; oob_m = 1'b0;
        check_eq("reset_ready", int'(rd_ready), 0);
        check_eq("reset_valid", int'(rd_valid), 0);
        check_eq("reset_color", int'(rd_color), 0);
        check_eq("reset_oob",   int'(rd_oob),   0);
        reset = 1'b0;
`ifdef PIXEL_READBACK_CLEAR_EN
        for (int i = 0; i < 160*120; i++) fb[i] = 3'd0;
        n = 0;
        while (!rd_ready && n < 30000) begin
            if (stall_write && n == 4) begin
                wr_x = 8'd0; wr_y = 7'd0; wr_color = 3'b010; wr_plot = 1'b1;
                fb[0] = 3'b010;
            end
            @(posedge clk); #1;
            n++;
            wr_plot = 1'b0;
        end
        check_eq("clear_cycles", n, stall_write ? 19201 : 19200);
        ready_m = 1'b1;
        startup = 1'b0;
`else
        n = int'(stall_write);
        startup = (n >= 0);
`endif
    endtask

    task automatic read_px(input int x, input int y, input int exp_color,
                           input int exp_oob, input string tag);
        int n;
        n = 0;
        rd_req = 1'b0;
        while (!ready_m && n < 10) begin
            tick();
            n++;
        end
        rd_x = 8'(x); rd_y = 7'(y); rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        check_eq({tag, "_valid"}, int'(rd_valid), 1);
        check_eq({tag, "_color"}, int'(rd_color), exp_color);
        check_eq({tag, "_oob"},   int'(rd_oob),   exp_oob);
    endtask

    task automatic plot(input int x, input int y, input logic [2:0] c);
        wr_x = 8'(x); wr_y = 7'(y); wr_color = c; wr_plot = 1'b1;
        tick();
        wr_plot = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_x = '0; wr_y = '0; wr_color = '0; wr_plot = 1'b0;
        rd_req = 1'b0; rd_x = '0; rd_y = '0;
        vcnt = 0; ready_m = 1'b0; valid_m = 1'b0; startup = 1'b0;
        oob_m = 1'b0; color_m = '0; pend_oob = 1'b0; pend_color = '0;
        for (int i = 0; i < 160*120; i++) fb[i] = 3'd0;

        do_reset(1'b0);
        tick();
`ifdef PIXEL_READBACK_CLEAR_EN
        read_px(159, 119, 0, 0, "clr_corner");
`endif
        // Give every in-range pixel of the random region a known colour.
        for (int yi = 0; yi < 10; yi++) begin
            for (int xi = 0; xi < 10; xi++) begin
                plot((xi < 6) ? xi : 150 + xi, (yi < 5) ? yi : 111 + yi, 3'($urandom));
            end
        end

        plot(10, 20, 3'b101);
        read_px(10, 20, 5, 0, "wr_rd");

        // Read accepted on the same edge as a write; the following write must not leak in.
        wr_x = 8'd5; wr_y = 7'd5; wr_color = 3'b011; wr_plot = 1'b1;
        rd_x = 8'd5; rd_y = 7'd5; rd_req = 1'b1;
        tick();
        rd_req = 1'b0; wr_color = 3'b110;
        tick();
        wr_plot = 1'b0;
        tick();
        check_eq("same_edge_color", int'(rd_color), 3);
        read_px(5, 5, 6, 0, "later_write");

        plot(160, 0, 3'b111);
        plot(0, 1, 3'b000);
        read_px(160, 0, 0, 1, "oob_read");
        read_px(0, 1, 0, 0, "oob_nowrite");

        for (int i = 0; i < 800; i++) begin
            wr_plot  = ($urandom_range(0, 1) == 1);
            wr_x     = 8'(rnd_coord(5, 156, 163));
            wr_y     = 7'(rnd_coord(4, 116, 123));
            wr_color = 3'($urandom);
            rd_req   = ($urandom_range(0, 1) == 1);
            rd_x     = 8'(rnd_coord(5, 156, 163));
            rd_y     = 7'(rnd_coord(4, 116, 123));
            tick();
        end
        wr_plot = 1'b0;
        rd_req  = 1'b0;
        tick();
        tick();

        read_px(10, 20, 5, 0, "pre_rst");
        rd_x = 8'd10; rd_y = 7'd20; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrd_ready", int'(rd_ready), 0);
        check_eq("midrd_valid", int'(rd_valid), 0);
        check_eq("midrd_color", int'(rd_color), 0);
        check_eq("midrd_oob",   int'(rd_oob),   0);
        do_reset(1'b1);
        repeat (4) tick();
`ifdef PIXEL_READBACK_CLEAR_EN
        read_px(0, 0, 2, 0, "clr_stall");
        read_px(10, 20, 0, 0, "clr_zeroed");
`else
        read_px(10, 20, 5, 0, "ram_kept");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
